// File: rtl/output_fifo_drain.sv
// Round-robin consumer for the four output FIFOs (fifo4..fifo7): pops one word per cycle,
// tags it with its source port, flags destination mismatches and keeps saturating counts.
module output_fifo_drain #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              enable,
    input  logic              fifo4_empty,
    input  logic              fifo5_empty,
    input  logic              fifo6_empty,
    input  logic              fifo7_empty,
    input  logic [DATA_W-1:0] fifo4_out,
    input  logic [DATA_W-1:0] fifo5_out,
    input  logic [DATA_W-1:0] fifo6_out,
    input  logic [DATA_W-1:0] fifo7_out,
    output logic              pop4,
    output logic              pop5,
    output logic              pop6,
    output logic              pop7,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        port_out,
    output logic              valid_out,
    output logic              dest_err,
    input  logic              req,
    input  logic [1:0]        idx,
    output logic [CNT_W-1:0]  counter_out,
    output logic              counter_valid
);

    typedef enum logic [1:0] {StInit, StIdle, StDrain} state_e;

    state_e            state_q;
    logic [1:0]        ptr_q;
    logic              valid_q;
    logic [1:0]        port_q;
    logic [CNT_W-1:0]  cnt_q [4];
    logic [CNT_W-1:0]  cnt_out_q;
    logic              cnt_valid_q;

    logic [3:0]        empty_v;
    logic [DATA_W-1:0] fifo_data [4];
    logic              grant_valid;
    logic [1:0]        grant_port;
    logic [1:0]        cand;
    logic              pop_en;
    logic [3:0]        pop_v;

    assign empty_v      = {fifo7_empty, fifo6_empty, fifo5_empty, fifo4_empty};
    assign fifo_data[0] = fifo4_out;
    assign fifo_data[1] = fifo5_out;
    assign fifo_data[2] = fifo6_out;
    assign fifo_data[3] = fifo7_out;

    // First non-empty port at or after the pointer, wrapping modulo 4.
    always_comb begin
        grant_valid = 1'b0;
        grant_port  = ptr_q;
        cand        = ptr_q;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!grant_valid && !empty_v[cand]) begin
                grant_valid = 1'b1;
                grant_port  = cand;
            end
        end
    end

    // Pops are combinational so enable/init can cut them off in the same cycle.
    assign pop_en = (state_q == StDrain) && enable && !init && grant_valid;
    assign pop_v  = pop_en ? (4'b0001 << grant_port) : 4'b0000;
    assign {pop7, pop6, pop5, pop4} = pop_v;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StInit;
            ptr_q   <= 2'd0;
            valid_q <= 1'b0;
            port_q  <= 2'd0;
        end else begin
            valid_q <= pop_en;
            port_q  <= pop_en ? grant_port : 2'd0;
            if (pop_en) begin
                ptr_q <= grant_port + 2'd1;
            end
            unique case (state_q)
                StInit: begin
                    if (!init) state_q <= StIdle;
                end
                StIdle: begin
                    if (init) state_q <= StInit;
                    else if (enable && !(&empty_v)) state_q <= StDrain;
                end
                StDrain: begin
                    if (init) state_q <= StInit;
                    else if (!enable || !grant_valid) state_q <= StIdle;
                end
                default: state_q <= StInit;
            endcase
        end
    end

    // Read data arrives the cycle after the pop, so the word is muxed straight through.
    assign data_out  = valid_q ? fifo_data[port_q] : '0;
    assign port_out  = port_q;
    assign valid_out = valid_q;
    assign dest_err  = valid_q && (data_out[DATA_W-1 -: 2] != port_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            cnt_out_q   <= '0;
            cnt_valid_q <= 1'b0;
        end else begin
            cnt_valid_q <= req;
            if (req) cnt_out_q <= cnt_q[idx];
            if (init || state_q == StInit) begin
                for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            end else if (valid_q && (cnt_q[port_q] != '1)) begin
                cnt_q[port_q] <= cnt_q[port_q] + CNT_W'(1);
            end
        end
    end

    assign counter_out   = cnt_out_q;
    assign counter_valid = cnt_valid_q;

endmodule
